branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter stage of the 5-stage MIPS pipeline: holds the fetch PC, produces PC+4, and commits branch and jump redirects. The branch offset arrives already sign-extended and shifted left by 2 from the shift-by-2 stage; this block adds it to the branch's PC+4 and steers fetch. Stalls from the hazard unit hold the PC. A redirect that resolves during a stall is buffered and committed when the stall releases.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hazard-unit hold; PC must not advance
- br_taken  in  1  branch in ID resolved taken this cycle
- jump  in  1  J/JAL in ID this cycle
- ctl_pc4  in  32  PC+4 of the instruction in ID (the branch or jump)
- br_offs  in  32  sign-extended immediate, already shifted left by 2
- jump_index  in  26  instr[25:0] of the jump
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4 (combinational)
- flush  out  1  squash IF/ID at this edge; high exactly in a redirect-commit cycle
- redirect_pending  out  1  high while a buffered redirect awaits stall release

## Operation
- Target arithmetic, 32-bit modulo 2^32, wraps silently:
  - branch target = ctl_pc4 + br_offs
  - jump target = {ctl_pc4[31:28], jump_index, 2'b00}
  - committed target bits [1:0] forced to 00
- Request = br_taken | jump. jump has priority when both are high.
- States:
  - RUN: redirect_pending = 0.
    - Request and !stall: pc <= target; flush = 1; stay in RUN.
    - Request and stall: latch target into tgt_q; go to HOLD; pc holds; flush = 0.
    - No request, !stall: pc <= pc + 4.
    - No request, stall: pc holds.
  - HOLD: redirect_pending = 1; pc holds.
    - stall still high: stay in HOLD. New requests are ignored and tgt_q is not overwritten.
    - stall low: pc <= tgt_q; flush = 1; go to RUN. Any request input in this cycle is ignored.
- flush is combinational from state and inputs; it is high only in commit cycles.
- Reset (any state, including HOLD):
  - pc <= RESET_PC; state <= RUN; tgt_q <= 0.
  - flush = 0 and redirect_pending = 0 while rst is high.
  - rst overrides stall and requests.

## Timing
- Output reset values: pc = RESET_PC; pc_plus4 = RESET_PC + 4; flush = 0; redirect_pending = 0.
- Unstalled redirect latency is one edge: request in cycle N gives pc = target in cycle N+1, with flush high in cycle N.
- Stalled redirect: pc = target one cycle after the first cycle in which stall is low.
- pc wrap: 32'hFFFF_FFFC + 4 gives 32'h0000_0000 with no flag.
- No combinational path from br_offs or jump_index to pc; the pc output is registered only.

## Structure
- Shared package/header (pipeline constants): state encodings ST_RUN and ST_HOLD, and the constant 32'd4.
- Target mux and adder are a natural sub-module `pc_target_gen` (purely combinational: jump/branch select, add, low-bit clear).
- Top level holds the pc register, tgt_q, the state FSM and the flush decode.

## Test plan
- Reset with RESET_PC = 32'h0040_0000, then 3 unstalled cycles -> pc = 0040_0000, 0040_0004, 0040_0008, 0040_000C; flush never high.
- br_taken with ctl_pc4 = 0040_0010 and br_offs = FFFF_FFF0 (-16), no stall -> flush high that cycle; next pc = 0040_0000.
- jump with ctl_pc4 = 1000_0008 and jump_index = 26'h0000100, together with br_taken -> jump wins; next pc = 1000_0400.
- br_taken (target 0040_0100) under stall held 3 cycles, with a different br_offs in cycle 2 -> redirect_pending high for 3 cycles; pc frozen; on stall release flush = 1; next pc = 0040_0100.
- rst asserted in the second HOLD cycle -> next pc = RESET_PC; redirect_pending = 0; no flush when stall later drops.
- pc = FFFF_FFFC with no request -> next pc = 0000_0000; branch with ctl_pc4 = FFFF_FFF0 and br_offs = 0000_0020 -> pc = 0000_0010.

Source files
------------

// File: rtl/branch_pc_unit_pkg.sv
// branch_pc_unit_pkg: shared pipeline constants and PC-stage state encodings
package branch_pc_unit_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/branch_pc_unit_target_gen.sv
// pc_target_gen: selects jump or branch target and forces word alignment
module pc_target_gen (
  input  logic        i_jump,
  input  logic [31:0] i_ctl_pc4,
  input  logic [31:0] i_br_offs,
  input  logic [25:0] i_jump_index,
  output logic [31:0] o_target
);
  logic [31:0] w_br_tgt;
  logic [31:0] w_jmp_tgt;
  assign w_br_tgt  = i_ctl_pc4 + i_br_offs;
  assign w_jmp_tgt = {i_ctl_pc4[31:28], i_jump_index, 2'b00};
  assign o_target  = (i_jump ? w_jmp_tgt : w_br_tgt) & ~32'd3;
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC register with stall hold and buffered branch/jump redirects
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] ctl_pc4,
  input  logic [31:0] br_offs,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        redirect_pending
);
  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] w_pc_nx;
  logic [31:0] w_tgt_nx;
  logic [31:0] w_target;
  logic        w_req;
  logic        w_run_commit;
  logic        w_hold_commit;
  logic        w_latch;

  pc_target_gen u_tgt (
    .i_jump       (jump),
    .i_ctl_pc4    (ctl_pc4),
    .i_br_offs    (br_offs),
    .i_jump_index (jump_index),
    .o_target     (w_target)
  );

  assign w_req    = br_taken | jump;
  assign pc       = r_pc;
  assign pc_plus4 = r_pc + PC_INC;

  // Next-state, next-pc and flush decode; a HOLD commit ignores new requests
  always_comb begin
    w_run_commit     = (r_state == ST_RUN) && w_req && !stall;
    w_latch          = (r_state == ST_RUN) && w_req && stall;
    w_hold_commit    = (r_state == ST_HOLD) && !stall;
    w_pc_nx          = w_run_commit ? w_target :
                       w_hold_commit ? r_tgt :
                       ((r_state == ST_RUN) && !stall) ? pc_plus4 : r_pc;
    w_tgt_nx         = w_latch ? w_target : r_tgt;
    w_state_nx       = w_latch ? ST_HOLD : w_hold_commit ? ST_RUN : r_state;
    flush            = !rst && (w_run_commit || w_hold_commit);
    redirect_pending = !rst && (r_state == ST_HOLD);
  end

  // PC, buffered target and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_nx;
      r_tgt   <= w_tgt_nx;
      r_state <= w_state_nx;
    end
  end
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed checks of PC sequencing, redirects, stalls and reset
module tb_branch_pc_unit;
  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jump;
  logic [31:0] ctl_pc4, br_offs;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4;
  logic        flush, redirect_pending;
  int          errors = 0;
  int          checks = 0;

  branch_pc_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .br_taken         (br_taken),
    .jump             (jump),
    .ctl_pc4          (ctl_pc4),
    .br_offs          (br_offs),
    .jump_index       (jump_index),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .flush            (flush),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
    ctl_pc4 = '0; br_offs = '0; jump_index = '0;
    step();
    step();
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_pc4", pc_plus4, 32'h0040_0004);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
    rst = 1'b0;
    #1;
    chk("run0_pc", pc, 32'h0040_0000);
    step();
    chk("run1_pc", pc, 32'h0040_0004);
    chk("run1_flush", {31'd0, flush}, 32'd0);
    step();
    chk("run2_pc", pc, 32'h0040_0008);
    step();
    chk("run3_pc", pc, 32'h0040_000C);
    chk("run3_flush", {31'd0, flush}, 32'd0);
    // backward branch, unstalled
    br_taken = 1'b1; ctl_pc4 = 32'h0040_0010; br_offs = 32'hFFFF_FFF0;
    #1;
    chk("br_flush", {31'd0, flush}, 32'd1);
    step();
    br_taken = 1'b0;
    #1;
    chk("br_pc", pc, 32'h0040_0000);
    chk("br_flush_after", {31'd0, flush}, 32'd0);
    // jump wins over simultaneous branch
    jump = 1'b1; br_taken = 1'b1; ctl_pc4 = 32'h1000_0008; jump_index = 26'h0000100; br_offs = 32'h0000_0040;
    #1;
    chk("jmp_flush", {31'd0, flush}, 32'd1);
    step();
    jump = 1'b0; br_taken = 1'b0;
    #1;
    chk("jmp_pc", pc, 32'h1000_0400);
    // branch under a 3-cycle stall, second offset ignored
    stall = 1'b1; br_taken = 1'b1; ctl_pc4 = 32'h0040_0080; br_offs = 32'h0000_0080;
    #1;
    chk("st1_flush", {31'd0, flush}, 32'd0);
    chk("st1_pend", {31'd0, redirect_pending}, 32'd0);
    step();
    br_offs = 32'h0000_0200;
    #1;
    chk("st2_pend", {31'd0, redirect_pending}, 32'd1);
    chk("st2_pc", pc, 32'h1000_0400);
    chk("st2_flush", {31'd0, flush}, 32'd0);
    step();
    br_taken = 1'b0;
    #1;
    chk("st3_pend", {31'd0, redirect_pending}, 32'd1);
    chk("st3_pc", pc, 32'h1000_0400);
    step();
    stall = 1'b0;
    #1;
    chk("rel_pend", {31'd0, redirect_pending}, 32'd1);
    chk("rel_flush", {31'd0, flush}, 32'd1);
    chk("rel_pc", pc, 32'h1000_0400);
    step();
    chk("commit_pc", pc, 32'h0040_0100);
    chk("commit_pend", {31'd0, redirect_pending}, 32'd0);
    chk("commit_flush", {31'd0, flush}, 32'd0);
    // reset in the second HOLD cycle drops the buffered redirect
    stall = 1'b1; br_taken = 1'b1; ctl_pc4 = 32'h0040_0080; br_offs = 32'h0000_1000;
    step();
    br_taken = 1'b0;
    #1;
    chk("h1_pend", {31'd0, redirect_pending}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("hrst_pend", {31'd0, redirect_pending}, 32'd0);
    chk("hrst_flush", {31'd0, flush}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("hrst_pc", pc, 32'h0040_0000);
    chk("hrst_pend2", {31'd0, redirect_pending}, 32'd0);
    stall = 1'b0;
    #1;
    chk("hrst_noflush", {31'd0, flush}, 32'd0);
    step();
    chk("hrst_adv", pc, 32'h0040_0004);
    chk("hrst_flush2", {31'd0, flush}, 32'd0);
    // wrap at top of address space
    jump = 1'b1; ctl_pc4 = 32'hF000_0000; jump_index = 26'h3FF_FFFF;
    step();
    jump = 1'b0;
    #1;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);
    step();
    chk("wrap_next", pc, 32'h0000_0000);
    br_taken = 1'b1; ctl_pc4 = 32'hFFFF_FFF0; br_offs = 32'h0000_0020;
    step();
    br_taken = 1'b0;
    #1;
    chk("brwrap_pc", pc, 32'h0000_0010);
    // misaligned sum has its low bits cleared
    br_taken = 1'b1; ctl_pc4 = 32'h0000_0100; br_offs = 32'h0000_0007;
    step();
    br_taken = 1'b0;
    #1;
    chk("align_pc", pc, 32'h0000_0104);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
